// File: rtl/sqrt_approx_seq.sv
// sqrt_approx_seq: sequential sqrt(A^2+B^2) estimate via max(x, x - x/8 + y/2) on a shared abs/min/max unit
// Build option: define SQRT_APPROX_ROUND_EN to round the shifted terms to nearest instead of truncating.

// AbsMinMax_16bit: shared abs/min/max unit (00 pass a, 01 |b|, 10 min(a,b), 11 max(a,b), signed compares)
module AbsMinMax_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [1:0]  op,
    output logic [15:0] y
);
    logic a_lt_b;
    assign a_lt_b = $signed(a) < $signed(b);
    // pure combinational op select
    always_comb begin
        y = op == 2'b00 ? a :
            op == 2'b01 ? (b[15] ? 16'(-b) : b) :
            op == 2'b10 ? (a_lt_b ? a : b) :
                          (a_lt_b ? b : a);
    end
endmodule

module sqrt_approx_seq (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Start,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic        Busy,
    output logic        Done,
    output logic [16:0] Result
);
    typedef enum logic [2:0] {IDLE, ABSA, ABSB, MAX, MIN, COMB} state_t;

    state_t      state_q, state_d;
    logic [15:0] ar_q, ar_d, br_q, br_d, pa_q, pa_d, pb_q, pb_d, x_q, x_d, y_q, y_d;
    logic [16:0] result_q, result_d;
    logic        done_q, done_d;
    logic [15:0] u_a, u_b, u_y;
    logic [1:0]  u_op;
    logic [16:0] x_ext, y_ext, t;

    AbsMinMax_16bit u_amm (.a(u_a), .b(u_b), .op(u_op), .y(u_y));

    // operands are at most 32767, so all 17-bit combine math stays in range
    assign x_ext = {1'b0, x_q};
    assign y_ext = {1'b0, y_q};
`ifdef SQRT_APPROX_ROUND_EN
    assign t = x_ext - ((x_ext + 17'd4) >> 3) + ((y_ext + 17'd1) >> 1);
`else
    assign t = x_ext - (x_ext >> 3) + (y_ext >> 1);
`endif

    // sequencer: one unit operation per state, results land in the matching register
    always_comb begin
        state_d  = state_q;
        ar_d     = ar_q;
        br_d     = br_q;
        pa_d     = pa_q;
        pb_d     = pb_q;
        x_d      = x_q;
        y_d      = y_q;
        result_d = result_q;
        done_d   = 1'b0;
        u_a      = '0;
        u_b      = '0;
        u_op     = 2'b00;
        case (state_q)
            IDLE: if (Start) begin
                ar_d    = A == 16'h8000 ? 16'h8001 : A;
                br_d    = B == 16'h8000 ? 16'h8001 : B;
                state_d = ABSA;
            end
            ABSA: begin
                u_b     = ar_q;
                u_op    = 2'b01;
                pa_d    = u_y;
                state_d = ABSB;
            end
            ABSB: begin
                u_b     = br_q;
                u_op    = 2'b01;
                pb_d    = u_y;
                state_d = MAX;
            end
            MAX: begin
                u_a     = pa_q;
                u_b     = pb_q;
                u_op    = 2'b11;
                x_d     = u_y;
                state_d = MIN;
            end
            MIN: begin
                u_a     = pa_q;
                u_b     = pb_q;
                u_op    = 2'b10;
                y_d     = u_y;
                state_d = COMB;
            end
            COMB: begin
                result_d = t > x_ext ? t : x_ext;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers with synchronous reset
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q  <= IDLE;
            ar_q     <= '0;
            br_q     <= '0;
            pa_q     <= '0;
            pb_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ar_q     <= ar_d;
            br_q     <= br_d;
            pa_q     <= pa_d;
            pb_q     <= pb_d;
            x_q      <= x_d;
            y_q      <= y_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign Busy   = state_q != IDLE;
    assign Done   = done_q;
    assign Result = result_q;
endmodule
